// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI inter-snoop controller: coherence-bus commands,
// broadcast request types and the snoop sequencer state encoding.
package mesi_isc_pkg;

    typedef enum logic [2:0] {
        CBUS_CMD_NOP      = 3'd0,
        CBUS_CMD_WR_SNOOP = 3'd1,
        CBUS_CMD_RD_SNOOP = 3'd2,
        CBUS_CMD_EN_WR    = 3'd3,
        CBUS_CMD_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic [1:0] {
        BREQ_TYPE_NOP = 2'd0,
        BREQ_TYPE_WR  = 2'd1,
        BREQ_TYPE_RD  = 2'd2
    } breq_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNOOP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_POP    = 2'd3
    } snoop_state_e;

endpackage

// File: rtl/mesi_isc_snoop_ack_tracker.sv
// Tracks which non-originating CPUs still owe a snoop acknowledge for the active request.
module mesi_isc_snoop_ack_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [1:0] cpu_id_i,
    input  logic [3:0] ack_i,
    output logic [3:0] pending_o,
    output logic       all_done_o
);

    logic [3:0] pending_q;
    logic [3:0] pending_d;

    // Acks on lanes that are not pending fall out of the AND and are ignored.
    always_comb begin
        pending_d = pending_q & ~ack_i;
        if (load_i) begin
            pending_d = ~(4'b0001 << cpu_id_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 4'b0000;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o  = pending_q;
    assign all_done_o = ((pending_q & ~ack_i) == 4'b0000);

endmodule

// File: rtl/mesi_isc_snoop_seq.sv
// Walks one broadcast request at a time through snoop, enable and FIFO pop
// on the four per-CPU coherence-bus lanes.
module mesi_isc_snoop_seq
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        broad_fifo_empty_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
    input  logic [3:0]                  cbus_ack_array_i,
    output logic                        broad_fifo_rd_o,
    output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
    output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
    output logic [BROAD_ID_WIDTH-1:0]   active_id_o,
    output logic                        busy_o
);

    snoop_state_e                state_q;
    snoop_state_e                state_d;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [BROAD_TYPE_WIDTH-1:0] type_q;
    logic [1:0]                  cpu_q;
    logic [BROAD_ID_WIDTH-1:0]   id_q;

    logic       head_is_wr;
    logic       head_is_rd;
    logic       accept;
    logic       latched_is_wr;
    logic [3:0] pending;
    logic       all_done;

    assign head_is_wr    = (broad_type_i == BROAD_TYPE_WIDTH'(BREQ_TYPE_WR));
    assign head_is_rd    = (broad_type_i == BROAD_TYPE_WIDTH'(BREQ_TYPE_RD));
    assign accept        = (state_q == ST_IDLE) && !broad_fifo_empty_i && (head_is_wr || head_is_rd);
    assign latched_is_wr = (type_q == BROAD_TYPE_WIDTH'(BREQ_TYPE_WR));

    mesi_isc_snoop_ack_tracker u_ack_tracker (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .cpu_id_i   (broad_cpu_id_i),
        .ack_i      (cbus_ack_array_i),
        .pending_o  (pending),
        .all_done_o (all_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            cpu_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= broad_addr_i;
                type_q <= broad_type_i;
                cpu_q  <= broad_cpu_id_i;
                id_q   <= broad_id_i;
            end
        end
    end

    // Heads with any type other than WR/RD are stale and are dropped without bus activity.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!broad_fifo_empty_i) begin
                    state_d = (head_is_wr || head_is_rd) ? ST_SNOOP : ST_POP;
                end
            end
            ST_SNOOP: begin
                if (all_done) begin
                    state_d = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                if (cbus_ack_array_i[cpu_q]) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cbus_cmd_array_o = '0;
        broad_fifo_rd_o  = (state_q == ST_POP);
        busy_o           = (state_q != ST_IDLE);
        unique case (state_q)
            ST_SNOOP: begin
                for (int i = 0; i < 4; i++) begin
                    if (pending[i]) begin
                        cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = latched_is_wr ?
                            CBUS_CMD_WIDTH'(CBUS_CMD_WR_SNOOP) : CBUS_CMD_WIDTH'(CBUS_CMD_RD_SNOOP);
                    end
                end
            end
            ST_ENABLE: begin
                cbus_cmd_array_o[int'(cpu_q)*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = latched_is_wr ?
                    CBUS_CMD_WIDTH'(CBUS_CMD_EN_WR) : CBUS_CMD_WIDTH'(CBUS_CMD_EN_RD);
            end
            default: begin
                cbus_cmd_array_o = '0;
            end
        endcase
    end

    assign cbus_addr_o = addr_q;
    assign active_id_o = id_q;

endmodule

// File: tb/tb_mesi_isc_snoop_seq.sv
// Directed self-checking bench for the snoop sequencer; expected lane commands are hand-computed.
module tb_mesi_isc_snoop_seq;

    logic        clk;
    logic        rst;
    logic        broadFifoEmpty;
    logic [31:0] broadAddr;
    logic [1:0]  broadType;
    logic [1:0]  broadCpuId;
    logic [6:0]  broadId;
    logic [3:0]  cbusAck;
    logic        broadFifoRd;
    logic [31:0] cbusAddr;
    logic [11:0] cbusCmdArray;
    logic [6:0]  activeId;
    logic        busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int popCount    = 0;

    mesi_isc_snoop_seq dut (
        .clk                (clk),
        .rst                (rst),
        .broad_fifo_empty_i (broadFifoEmpty),
        .broad_addr_i       (broadAddr),
        .broad_type_i       (broadType),
        .broad_cpu_id_i     (broadCpuId),
        .broad_id_i         (broadId),
        .cbus_ack_array_i   (cbusAck),
        .broad_fifo_rd_o    (broadFifoRd),
        .cbus_addr_o        (cbusAddr),
        .cbus_cmd_array_o   (cbusCmdArray),
        .active_id_o        (activeId),
        .busy_o             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (broadFifoRd) popCount++;
    end

    function automatic logic [11:0] lanes(input logic [2:0] l0, input logic [2:0] l1,
                                          input logic [2:0] l2, input logic [2:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic empty, input logic [1:0] typ, input logic [1:0] cpu,
                                 input logic [31:0] addr, input logic [6:0] id);
        broadFifoEmpty = empty;
        broadType      = typ;
        broadCpuId     = cpu;
        broadAddr      = addr;
        broadId        = id;
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseAck(input logic [3:0] ack);
        cbusAck = ack;
        stepCycle();
        cbusAck = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        cbusAck = 4'b0000;
        applyStimulus(1'b1, 2'd0, 2'd0, 32'h0, 7'h0);
        #12;
        checkOutput("reset_cmd",  32'(cbusCmdArray), 32'h0);
        checkOutput("reset_busy", 32'(busy),         32'h0);
        checkOutput("reset_rd",   32'(broadFifoRd),  32'h0);
        checkOutput("reset_addr", cbusAddr,          32'h0);
        checkOutput("reset_id",   32'(activeId),     32'h0);
        rst = 1'b0;
        stepCycle();

        // Request 1: RD from CPU2, head is scrambled after latch to prove the fields are frozen.
        applyStimulus(1'b0, 2'd2, 2'd2, 32'h1000_0040, 7'd5);
        stepCycle();
        checkOutput("rd_snoop_cmd",  32'(cbusCmdArray), 32'(lanes(3'd2, 3'd2, 3'd0, 3'd2)));
        checkOutput("rd_snoop_busy", 32'(busy),         32'h1);
        checkOutput("rd_snoop_addr", cbusAddr,          32'h1000_0040);
        checkOutput("rd_snoop_id",   32'(activeId),     32'd5);
        applyStimulus(1'b0, 2'd1, 2'd1, 32'hDEAD_BEEF, 7'd9);
        stepCycle();
        checkOutput("rd_hold_cmd",   32'(cbusCmdArray), 32'(lanes(3'd2, 3'd2, 3'd0, 3'd2)));
        checkOutput("rd_frozen_addr", cbusAddr,         32'h1000_0040);
        pulseAck(4'b0011);
        checkOutput("rd_ack01_cmd",  32'(cbusCmdArray), 32'(lanes(3'd0, 3'd0, 3'd0, 3'd2)));
        pulseAck(4'b0101);
        checkOutput("spurious_cmd",  32'(cbusCmdArray), 32'(lanes(3'd0, 3'd0, 3'd0, 3'd2)));
        checkOutput("spurious_busy", 32'(busy),         32'h1);
        pulseAck(4'b1000);
        checkOutput("rd_enable_cmd", 32'(cbusCmdArray), 32'(lanes(3'd0, 3'd0, 3'd4, 3'd0)));
        checkOutput("rd_enable_rd",  32'(broadFifoRd),  32'h0);
        pulseAck(4'b0001);
        checkOutput("enable_wrong_ack", 32'(cbusCmdArray), 32'(lanes(3'd0, 3'd0, 3'd4, 3'd0)));
        pulseAck(4'b0100);
        checkOutput("rd_pop_rd",   32'(broadFifoRd),  32'h1);
        checkOutput("rd_pop_cmd",  32'(cbusCmdArray), 32'h0);
        checkOutput("rd_pop_id",   32'(activeId),     32'd5);
        broadFifoEmpty = 1'b1;
        stepCycle();
        checkOutput("rd_idle_rd",   32'(broadFifoRd), 32'h0);
        checkOutput("rd_idle_busy", 32'(busy),        32'h0);
        checkOutput("rd_pop_count", 32'(popCount),    32'd1);

        // Request 2: WR from CPU0.
        applyStimulus(1'b0, 2'd1, 2'd0, 32'h2000_0080, 7'h11);
        stepCycle();
        checkOutput("wr_snoop_cmd", 32'(cbusCmdArray), 32'(lanes(3'd0, 3'd1, 3'd1, 3'd1)));
        checkOutput("wr_snoop_id",  32'(activeId),     32'h11);
        pulseAck(4'b1110);
        checkOutput("wr_enable_cmd", 32'(cbusCmdArray), 32'(lanes(3'd3, 3'd0, 3'd0, 3'd0)));
        pulseAck(4'b0001);
        checkOutput("wr_pop_rd", 32'(broadFifoRd), 32'h1);
        broadFifoEmpty = 1'b1;
        stepCycle();
        checkOutput("wr_pop_count", 32'(popCount), 32'd2);

        // Stale NOP head: discarded with a single pop and no bus activity.
        applyStimulus(1'b0, 2'd0, 2'd3, 32'h0BAD_0000, 7'h40);
        stepCycle();
        checkOutput("nop_pop_rd",   32'(broadFifoRd),  32'h1);
        checkOutput("nop_pop_cmd",  32'(cbusCmdArray), 32'h0);
        checkOutput("nop_pop_busy", 32'(busy),         32'h1);
        broadFifoEmpty = 1'b1;
        stepCycle();
        checkOutput("nop_idle_busy", 32'(busy),         32'h0);
        checkOutput("nop_idle_cmd",  32'(cbusCmdArray), 32'h0);
        checkOutput("nop_pop_count", 32'(popCount),     32'd3);

        // Two queued entries: the second is only latched once the first has popped.
        applyStimulus(1'b0, 2'd2, 2'd1, 32'h3000_0000, 7'h21);
        stepCycle();
        checkOutput("q1_snoop_cmd", 32'(cbusCmdArray), 32'(lanes(3'd2, 3'd0, 3'd2, 3'd2)));
        pulseAck(4'b1101);
        checkOutput("q1_enable_cmd", 32'(cbusCmdArray), 32'(lanes(3'd0, 3'd4, 3'd0, 3'd0)));
        pulseAck(4'b0010);
        checkOutput("q1_pop_rd", 32'(broadFifoRd), 32'h1);
        applyStimulus(1'b0, 2'd1, 2'd3, 32'h4000_0000, 7'h22);
        stepCycle();
        checkOutput("q_gap_busy", 32'(busy),        32'h0);
        checkOutput("q_gap_rd",   32'(broadFifoRd), 32'h0);
        checkOutput("q_gap_id",   32'(activeId),    32'h21);
        stepCycle();
        checkOutput("q2_snoop_cmd",  32'(cbusCmdArray), 32'(lanes(3'd1, 3'd1, 3'd1, 3'd0)));
        checkOutput("q2_snoop_id",   32'(activeId),     32'h22);
        checkOutput("q2_snoop_addr", cbusAddr,          32'h4000_0000);
        checkOutput("q_mid_pop_count", 32'(popCount),   32'd4);
        pulseAck(4'b0111);
        checkOutput("q2_enable_cmd", 32'(cbusCmdArray), 32'(lanes(3'd0, 3'd0, 3'd0, 3'd3)));
        pulseAck(4'b1000);
        checkOutput("q2_pop_rd", 32'(broadFifoRd), 32'h1);
        broadFifoEmpty = 1'b1;
        stepCycle();
        checkOutput("q_pop_count", 32'(popCount), 32'd5);

        // Reset in the middle of SNOOP, then the same head restarts cleanly.
        applyStimulus(1'b0, 2'd2, 2'd0, 32'h5000_0000, 7'h33);
        stepCycle();
        checkOutput("rst_pre_cmd", 32'(cbusCmdArray), 32'(lanes(3'd0, 3'd2, 3'd2, 3'd2)));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_cmd",  32'(cbusCmdArray), 32'h0);
        checkOutput("rst_async_busy", 32'(busy),         32'h0);
        checkOutput("rst_async_addr", cbusAddr,          32'h0);
        checkOutput("rst_async_id",   32'(activeId),     32'h0);
        checkOutput("rst_async_rd",   32'(broadFifoRd),  32'h0);
        stepCycle();
        rst = 1'b0;
        checkOutput("rst_no_pop", 32'(popCount), 32'd5);
        stepCycle();
        checkOutput("restart_cmd", 32'(cbusCmdArray), 32'(lanes(3'd0, 3'd2, 3'd2, 3'd2)));
        checkOutput("restart_id",  32'(activeId),     32'h33);
        pulseAck(4'b1110);
        checkOutput("restart_enable_cmd", 32'(cbusCmdArray), 32'(lanes(3'd4, 3'd0, 3'd0, 3'd0)));
        pulseAck(4'b0001);
        checkOutput("restart_pop_rd", 32'(broadFifoRd), 32'h1);
        broadFifoEmpty = 1'b1;
        stepCycle();
        checkOutput("restart_pop_count", 32'(popCount), 32'd6);
        checkOutput("final_busy",        32'(busy),     32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
